// File: rtl/assembler_pkg.sv
// Shared assembler types: instruction formats, operand slot kinds, the per-format
// slot table and the error codes reported by the operand sequencer.
package assembler_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    typedef enum logic [2:0] {
        SLOT_RD   = 3'd0,
        SLOT_RS1  = 3'd1,
        SLOT_RS2  = 3'd2,
        SLOT_IMM  = 3'd3,
        SLOT_NONE = 3'd4
    } slot_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PARSE = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_REG  = 2'd1;
    localparam logic [1:0] ERR_IMM  = 2'd2;
    localparam logic [1:0] ERR_FMT  = 2'd3;

    function automatic logic fmt_known(input logic [2:0] fmt);
        return (fmt <= 3'd5);
    endfunction

    // Operand order per format; any index past the last operand yields SLOT_NONE.
    function automatic slot_kind_t slot_kind(input fmt_t fmt, input logic [1:0] idx);
        slot_kind_t k;
        k = SLOT_NONE;
        case (fmt)
            FMT_R:   k = (idx == 2'd0) ? SLOT_RD  : (idx == 2'd1) ? SLOT_RS1 : (idx == 2'd2) ? SLOT_RS2 : SLOT_NONE;
            FMT_I:   k = (idx == 2'd0) ? SLOT_RD  : (idx == 2'd1) ? SLOT_RS1 : (idx == 2'd2) ? SLOT_IMM : SLOT_NONE;
            FMT_S:   k = (idx == 2'd0) ? SLOT_RS2 : (idx == 2'd1) ? SLOT_RS1 : (idx == 2'd2) ? SLOT_IMM : SLOT_NONE;
            FMT_B:   k = (idx == 2'd0) ? SLOT_RS1 : (idx == 2'd1) ? SLOT_RS2 : (idx == 2'd2) ? SLOT_IMM : SLOT_NONE;
            FMT_U:   k = (idx == 2'd0) ? SLOT_RD  : (idx == 2'd1) ? SLOT_IMM : SLOT_NONE;
            FMT_J:   k = (idx == 2'd0) ? SLOT_RD  : (idx == 2'd1) ? SLOT_IMM : SLOT_NONE;
            default: k = SLOT_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/operand_skid.sv
// One-entry character holding register: captures a strobe that arrives while the
// parsers are held in reset and offers it back for replay; flush has priority.
module operand_skid (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       load,
    input  logic       flush,
    input  logic [7:0] data_in,
    output logic       valid,
    output logic [7:0] data
);

    logic       valid_r;
    logic [7:0] data_r;

    // Holding register with synchronous clear.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            valid_r <= 1'b0;
            data_r  <= 8'd0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= data_in;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/operand_sequencer.sv
// Walks the operand slots of one decoded instruction, steering characters to the
// register or immediate parser. Optional per-slot timeout: OPERAND_TIMEOUT_EN.
module operand_sequencer
    import assembler_pkg::*;
#(
    parameter int IMM_WIDTH         = 32,
    parameter int MAX_OPERAND_CHARS = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [2:0]           format_in,
    input  logic                 valid_data,
    input  logic                 new_character,
    input  logic [7:0]           incoming_ascii,
    output logic                 reg_valid_out,
    output logic                 imm_valid_out,
    output logic                 fwd_new_char_out,
    output logic [7:0]           fwd_ascii_out,
    input  logic                 reg_done_in,
    input  logic                 reg_error_in,
    input  logic [4:0]           reg_value_in,
    input  logic                 imm_done_in,
    input  logic                 imm_error_in,
    input  logic [IMM_WIDTH-1:0] imm_value_in,
    output logic [4:0]           rd_out,
    output logic [4:0]           rs1_out,
    output logic [4:0]           rs2_out,
    output logic [IMM_WIDTH-1:0] imm_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out,
    output logic [1:0]           error_code_out
);

    seq_state_t            state_r, state_nx_s;
    fmt_t                  fmt_r;
    logic [1:0]            slot_r;
    logic [4:0]            rd_r, rs1_r, rs2_r;
    logic [IMM_WIDTH-1:0]  imm_r;
    logic [1:0]            err_code_r;
    slot_kind_t            kind_s;
    logic                  is_reg_s, is_imm_s, act_done_s, act_err_s, last_s, timeout_s;
    logic                  skid_valid_s;
    logic [7:0]            skid_data_s;

    assign kind_s     = slot_kind(fmt_r, slot_r);
    assign is_reg_s   = (kind_s == SLOT_RD) || (kind_s == SLOT_RS1) || (kind_s == SLOT_RS2);
    assign is_imm_s   = (kind_s == SLOT_IMM);
    assign act_done_s = (is_reg_s && reg_done_in) || (is_imm_s && imm_done_in);
    assign act_err_s  = (is_reg_s && reg_error_in) || (is_imm_s && imm_error_in);
    assign last_s     = (slot_kind(fmt_r, slot_r + 2'd1) == SLOT_NONE);

    operand_skid u_skid (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .load    ((state_r == ST_GAP) && new_character && valid_data),
        .flush   (state_r != ST_GAP),
        .data_in (incoming_ascii),
        .valid   (skid_valid_s),
        .data    (skid_data_s)
    );

`ifdef OPERAND_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_OPERAND_CHARS + 1);
    logic [CNT_W-1:0] char_cnt_r;

    // Characters forwarded in the current slot; the GAP before each slot clears it.
    always_ff @(posedge clk_in) begin
        if (rst_in || (state_r != ST_PARSE)) begin
            char_cnt_r <= {CNT_W{1'b0}};
        end else if (fwd_new_char_out) begin
            char_cnt_r <= char_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            char_cnt_r <= char_cnt_r;
        end
    end

    assign timeout_s = (state_r == ST_PARSE) && (char_cnt_r == CNT_W'(MAX_OPERAND_CHARS));
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; losing the stream overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (!valid_data) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_ERROR: state_nx_s = !start_in ? state_r :
                                                fmt_known(format_in) ? ST_PARSE : ST_ERROR;
                ST_PARSE:          state_nx_s = act_err_s  ? ST_ERROR :
                                                act_done_s ? (last_s ? ST_DONE : ST_GAP) :
                                                timeout_s  ? ST_ERROR : ST_PARSE;
                ST_GAP:            state_nx_s = ST_PARSE;
                ST_DONE:           state_nx_s = ST_IDLE;
                default:           state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Format latch, slot index, field capture and error code.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fmt_r      <= FMT_R;
            slot_r     <= 2'd0;
            rd_r       <= 5'd0;
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            imm_r      <= {IMM_WIDTH{1'b0}};
            err_code_r <= ERR_NONE;
        end else if (valid_data) begin
            case (state_r)
                ST_IDLE, ST_ERROR: begin
                    if (start_in) begin
                        fmt_r      <= fmt_t'(format_in);
                        slot_r     <= 2'd0;
                        rd_r       <= 5'd0;
                        rs1_r      <= 5'd0;
                        rs2_r      <= 5'd0;
                        imm_r      <= {IMM_WIDTH{1'b0}};
                        err_code_r <= fmt_known(format_in) ? ERR_NONE : ERR_FMT;
                    end
                end
                ST_PARSE: begin
                    if (act_err_s) begin
                        err_code_r <= is_reg_s ? ERR_REG : ERR_IMM;
                    end else if (act_done_s) begin
                        case (kind_s)
                            SLOT_RD:  rd_r  <= reg_value_in;
                            SLOT_RS1: rs1_r <= reg_value_in;
                            SLOT_RS2: rs2_r <= reg_value_in;
                            SLOT_IMM: imm_r <= imm_value_in;
                            default:  rd_r  <= rd_r;
                        endcase
                        slot_r <= last_s ? slot_r : slot_r + 2'd1;
                    end else if (timeout_s) begin
                        err_code_r <= ERR_FMT;
                    end
                end
                default: slot_r <= slot_r;
            endcase
        end
    end

    // Parser steering and status decode from the current state.
    always_comb begin
        reg_valid_out    = 1'b0;
        imm_valid_out    = 1'b0;
        fwd_new_char_out = 1'b0;
        fwd_ascii_out    = 8'd0;
        busy_out         = 1'b0;
        done_out         = 1'b0;
        error_out        = 1'b0;
        case (state_r)
            ST_PARSE: begin
                reg_valid_out    = is_reg_s;
                imm_valid_out    = is_imm_s;
                fwd_new_char_out = new_character || skid_valid_s;
                fwd_ascii_out    = skid_valid_s ? skid_data_s : incoming_ascii;
                busy_out         = 1'b1;
            end
            ST_GAP:   busy_out  = 1'b1;
            ST_DONE:  done_out  = 1'b1;
            ST_ERROR: error_out = 1'b1;
            default:  busy_out  = 1'b0;
        endcase
    end

    assign rd_out         = rd_r;
    assign rs1_out        = rs1_r;
    assign rs2_out        = rs2_r;
    assign imm_out        = imm_r;
    assign error_code_out = err_code_r;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: R/I formats, error and restart, skid replay,
// abort and reset mid-slot, bad format, and the timeout when built with OPERAND_TIMEOUT_EN.
module tb_operand_sequencer;

    localparam int IMM_WIDTH = 32;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 start_in = 1'b0;
    logic [2:0]           format_in = 3'd0;
    logic                 valid_data = 1'b0;
    logic                 new_character = 1'b0;
    logic [7:0]           incoming_ascii = 8'd0;
    logic                 reg_valid_out, imm_valid_out, fwd_new_char_out;
    logic [7:0]           fwd_ascii_out;
    logic                 reg_done_in = 1'b0, reg_error_in = 1'b0;
    logic [4:0]           reg_value_in = 5'd0;
    logic                 imm_done_in = 1'b0, imm_error_in = 1'b0;
    logic [IMM_WIDTH-1:0] imm_value_in = 32'd0;
    logic [4:0]           rd_out, rs1_out, rs2_out;
    logic [IMM_WIDTH-1:0] imm_out;
    logic                 busy_out, done_out, error_out;
    logic [1:0]           error_code_out;

    int checks = 0;
    int errors = 0;

    operand_sequencer #(.IMM_WIDTH(IMM_WIDTH), .MAX_OPERAND_CHARS(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .format_in(format_in),
        .valid_data(valid_data), .new_character(new_character), .incoming_ascii(incoming_ascii),
        .reg_valid_out(reg_valid_out), .imm_valid_out(imm_valid_out),
        .fwd_new_char_out(fwd_new_char_out), .fwd_ascii_out(fwd_ascii_out),
        .reg_done_in(reg_done_in), .reg_error_in(reg_error_in), .reg_value_in(reg_value_in),
        .imm_done_in(imm_done_in), .imm_error_in(imm_error_in), .imm_value_in(imm_value_in),
        .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .imm_out(imm_out),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
        .error_code_out(error_code_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic pulse_reg(input logic [4:0] v);
        reg_done_in = 1'b1; reg_value_in = v; tick(); reg_done_in = 1'b0;
    endtask

    task automatic pulse_imm(input logic [31:0] v);
        imm_done_in = 1'b1; imm_value_in = v; tick(); imm_done_in = 1'b0;
    endtask

    task automatic start_fmt(input logic [2:0] f);
        start_in = 1'b1; format_in = f; tick(); start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_data = 1'b1; tick(); tick(); rst_in = 1'b0;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_out); end
        checks++; if ({done_out, error_out, error_code_out} !== 4'd0) begin errors++; $display("FAIL reset_status: got %b expected 0000", {done_out, error_out, error_code_out}); end
        checks++; if ({rd_out, rs1_out, rs2_out} !== 15'd0 || imm_out !== 32'd0) begin errors++; $display("FAIL reset_fields: got %0d %0d %0d %0d expected 0", rd_out, rs1_out, rs2_out, imm_out); end
        checks++; if ({reg_valid_out, imm_valid_out, fwd_new_char_out} !== 3'd0) begin errors++; $display("FAIL reset_valids: got %b expected 000", {reg_valid_out, imm_valid_out, fwd_new_char_out}); end
    endtask

    task automatic test_r_format();
        start_fmt(3'd0);
        checks++; if ({busy_out, reg_valid_out, imm_valid_out} !== 3'b110) begin errors++; $display("FAIL r_slot0_valids: got %b expected 110", {busy_out, reg_valid_out, imm_valid_out}); end
        new_character = 1'b1; incoming_ascii = 8'h72; #1;
        checks++; if (fwd_new_char_out !== 1'b1 || fwd_ascii_out !== 8'h72) begin errors++; $display("FAIL r_forward: got %b %h expected 1 72", fwd_new_char_out, fwd_ascii_out); end
        tick(); new_character = 1'b0;
        pulse_reg(5'd1);
        checks++; if (reg_valid_out !== 1'b0 || rd_out !== 5'd1) begin errors++; $display("FAIL r_gap0: got valid %b rd %0d expected 0 1", reg_valid_out, rd_out); end
        tick();
        start_in = 1'b1; format_in = 3'd3;   // ignored while busy
        pulse_reg(5'd2); start_in = 1'b0; tick();
        pulse_reg(5'd31);
        checks++; if (done_out !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL r_done: got done %b busy %b expected 1 0", done_out, busy_out); end
        checks++; if (rd_out !== 5'd1 || rs1_out !== 5'd2 || rs2_out !== 5'd31) begin errors++; $display("FAIL r_fields: got %0d %0d %0d expected 1 2 31", rd_out, rs1_out, rs2_out); end
        tick();
        checks++; if (done_out !== 1'b0 || rd_out !== 5'd1) begin errors++; $display("FAIL r_after: got done %b rd %0d expected 0 1", done_out, rd_out); end
    endtask

    task automatic test_i_format();
        start_fmt(3'd1);
        checks++; if (imm_valid_out !== 1'b0 || reg_valid_out !== 1'b1) begin errors++; $display("FAIL i_slot0_valids: got reg %b imm %b expected 1 0", reg_valid_out, imm_valid_out); end
        pulse_imm(32'd77);   // inactive parser, ignored
        checks++; if (reg_valid_out !== 1'b1 || imm_out !== 32'd0) begin errors++; $display("FAIL i_inactive_imm: got valid %b imm %0d expected 1 0", reg_valid_out, imm_out); end
        pulse_reg(5'd5); tick(); pulse_reg(5'd6);
        checks++; if ({reg_valid_out, imm_valid_out, busy_out} !== 3'b001) begin errors++; $display("FAIL i_gap1: got %b expected 001", {reg_valid_out, imm_valid_out, busy_out}); end
        tick();
        checks++; if (imm_valid_out !== 1'b1 || reg_valid_out !== 1'b0) begin errors++; $display("FAIL i_slot2_valids: got reg %b imm %b expected 0 1", reg_valid_out, imm_valid_out); end
        pulse_reg(5'd20);
        checks++; if (imm_valid_out !== 1'b1 || done_out !== 1'b0) begin errors++; $display("FAIL i_inactive_reg: got imm_valid %b done %b expected 1 0", imm_valid_out, done_out); end
        pulse_imm(32'd100);
        checks++; if (done_out !== 1'b1 || imm_out !== 32'd100 || rd_out !== 5'd5 || rs1_out !== 5'd6) begin errors++; $display("FAIL i_done: got done %b imm %0d rd %0d rs1 %0d expected 1 100 5 6", done_out, imm_out, rd_out, rs1_out); end
        tick();
    endtask

    task automatic test_b_error_restart();
        start_fmt(3'd3);
        pulse_reg(5'd7); tick();
        reg_error_in = 1'b1; pulse_reg(5'd12); reg_error_in = 1'b0;
        checks++; if (error_out !== 1'b1 || error_code_out !== 2'd1 || busy_out !== 1'b0 || done_out !== 1'b0) begin errors++; $display("FAIL b_error: got err %b code %0d busy %b done %b expected 1 1 0 0", error_out, error_code_out, busy_out, done_out); end
        checks++; if (rs2_out !== 5'd0 || rs1_out !== 5'd7) begin errors++; $display("FAIL b_no_capture: got rs1 %0d rs2 %0d expected 7 0", rs1_out, rs2_out); end
        tick();
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL b_error_hold: got %b expected 1", error_out); end
        start_fmt(3'd0);
        checks++; if (error_out !== 1'b0 || error_code_out !== 2'd0 || rs1_out !== 5'd0 || reg_valid_out !== 1'b1) begin errors++; $display("FAIL b_restart: got err %b code %0d rs1 %0d rv %b expected 0 0 0 1", error_out, error_code_out, rs1_out, reg_valid_out); end
        pulse_reg(5'd9);
        checks++; if (rd_out !== 5'd9) begin errors++; $display("FAIL b_restart_rd: got %0d expected 9", rd_out); end
        valid_data = 1'b0; tick(); valid_data = 1'b1;
    endtask

    task automatic test_skid_and_abort();
        start_fmt(3'd1);
        pulse_reg(5'd3);
        new_character = 1'b1; incoming_ascii = 8'h72; #1;
        checks++; if (fwd_new_char_out !== 1'b0) begin errors++; $display("FAIL skid_gap_blocked: got %b expected 0", fwd_new_char_out); end
        tick(); new_character = 1'b0; incoming_ascii = 8'h00; #1;
        checks++; if (fwd_new_char_out !== 1'b1 || fwd_ascii_out !== 8'h72) begin errors++; $display("FAIL skid_replay: got %b %h expected 1 72", fwd_new_char_out, fwd_ascii_out); end
        tick();
        checks++; if (fwd_new_char_out !== 1'b0) begin errors++; $display("FAIL skid_drained: got %b expected 0", fwd_new_char_out); end
        valid_data = 1'b0; tick(); valid_data = 1'b1;
        checks++; if (busy_out !== 1'b0 || done_out !== 1'b0 || error_out !== 1'b0 || rd_out !== 5'd3) begin errors++; $display("FAIL abort: got busy %b done %b err %b rd %0d expected 0 0 0 3", busy_out, done_out, error_out, rd_out); end
    endtask

    task automatic test_reset_mid_slot();
        start_fmt(3'd0);
        pulse_reg(5'd4);
        new_character = 1'b1; incoming_ascii = 8'h78; rst_in = 1'b1;
        tick(); new_character = 1'b0; rst_in = 1'b0;
        checks++; if (busy_out !== 1'b0 || rd_out !== 5'd0) begin errors++; $display("FAIL rst_gap: got busy %b rd %0d expected 0 0", busy_out, rd_out); end
        start_fmt(3'd0);
        checks++; if (fwd_new_char_out !== 1'b0) begin errors++; $display("FAIL rst_skid_empty: got %b expected 0", fwd_new_char_out); end
        pulse_reg(5'd8); tick();
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        checks++; if (busy_out !== 1'b0 || done_out !== 1'b0 || rd_out !== 5'd0) begin errors++; $display("FAIL rst_slot1: got busy %b done %b rd %0d expected 0 0 0", busy_out, done_out, rd_out); end
    endtask

    task automatic test_bad_format();
        start_fmt(3'd6);
        checks++; if (error_out !== 1'b1 || error_code_out !== 2'd3 || busy_out !== 1'b0) begin errors++; $display("FAIL bad_fmt: got err %b code %0d busy %b expected 1 3 0", error_out, error_code_out, busy_out); end
        valid_data = 1'b0; tick(); valid_data = 1'b1;
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL bad_fmt_abort: got %b expected 0", error_out); end
    endtask

`ifdef OPERAND_TIMEOUT_EN
    task automatic test_timeout();
        start_fmt(3'd0);
        for (int i = 0; i < 16; i++) begin
            new_character = 1'b1; incoming_ascii = 8'h31; tick();
            new_character = 1'b0; tick();
        end
        checks++; if (error_out !== 1'b1 || error_code_out !== 2'd3) begin errors++; $display("FAIL timeout: got err %b code %0d expected 1 3", error_out, error_code_out); end
        valid_data = 1'b0; tick(); valid_data = 1'b1;
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_r_format();
        test_i_format();
        test_b_error_restart();
        test_skid_and_abort();
        test_reset_mid_slot();
        test_bad_format();
`ifdef OPERAND_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
